// File: rtl/iq_entry_ctrl.sv
// iq_entry_ctrl: issue-queue slot bookkeeping between dispatch and select.
// Holds the valid, src-ready and src-tag state of every slot. It allocates the
// lowest free slot on dispatch and applies wakeup broadcasts. It drives the
// per-slot request vector and frees the slot picked by the selector.
// Per-slot lifecycle: FREE -> WAIT (valid, a source pending) -> READY (valid,
// both sources ready) -> FREE on grant. The state is held as the valid/s1_rdy/s2_rdy bits.
// Optional feature macro: IQ_WAKEUP_BYPASS_EN (folds a wakeup that coincides
// with dispatch into the dispatched source-ready bits).
module iq_entry_ctrl #(
  parameter int ENT_NUM = 16,
  parameter int ENT_SEL = 4,
  parameter int TAG_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_valid,
  output logic               disp_ready,
  output logic [ENT_SEL-1:0] disp_ent,
  input  logic               disp_s1_rdy,
  input  logic [TAG_W-1:0]   disp_s1_tag,
  input  logic               disp_s2_rdy,
  input  logic [TAG_W-1:0]   disp_s2_tag,
  input  logic               wk_valid,
  input  logic [TAG_W-1:0]   wk_tag,
  output logic [ENT_NUM-1:0] request,
  input  logic               grant,
  input  logic [ENT_SEL-1:0] selected_ent,
  input  logic               flush,
  output logic [ENT_SEL:0]   occupancy,
  output logic               empty
);

  // Wakeup tag comparison shared by the slot wakeup and the dispatch bypass.
  function automatic logic tag_hit(input logic               wv,
                                   input logic [TAG_W-1:0] a,
                                   input logic [TAG_W-1:0] b);
    return wv & (a == b);
  endfunction

  logic [ENT_NUM-1:0] valid_q,  valid_d;
  logic [ENT_NUM-1:0] s1_rdy_q, s1_rdy_d;
  logic [ENT_NUM-1:0] s2_rdy_q, s2_rdy_d;
  logic [TAG_W-1:0]   s1_tag_q [ENT_NUM];
  logic [TAG_W-1:0]   s1_tag_d [ENT_NUM];
  logic [TAG_W-1:0]   s2_tag_q [ENT_NUM];
  logic [TAG_W-1:0]   s2_tag_d [ENT_NUM];
  logic [ENT_SEL:0]   occ_q,    occ_d;

  logic disp_fire_s;
  logic issue_fire_s;
  logic disp_s1_rdy_s;
  logic disp_s2_rdy_s;

  // A dispatched source is ready when marked so upstream, optionally also
  // when the wakeup broadcast in the same cycle names its tag.
`ifdef IQ_WAKEUP_BYPASS_EN
  assign disp_s1_rdy_s = disp_s1_rdy | tag_hit(wk_valid, wk_tag, disp_s1_tag);
  assign disp_s2_rdy_s = disp_s2_rdy | tag_hit(wk_valid, wk_tag, disp_s2_tag);
`else
  assign disp_s1_rdy_s = disp_s1_rdy;
  assign disp_s2_rdy_s = disp_s2_rdy;
`endif

  assign request      = valid_q & s1_rdy_q & s2_rdy_q;
  assign disp_ready   = ~&valid_q;
  assign disp_fire_s  = disp_valid & disp_ready;
  assign issue_fire_s = grant & valid_q[selected_ent];
  assign occupancy    = occ_q;
  assign empty        = (occ_q == {(ENT_SEL+1){1'b0}});

  // Lowest free slot. Scan from the top so that the lowest free index is written last.
  // The result is computed from the current valid vector only, so a slot freed this cycle is not offered.
  always_comb begin
    disp_ent = {ENT_SEL{1'b0}};
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      disp_ent = valid_q[i] ? disp_ent : ENT_SEL'(i);
    end
  end

  // Next-state for all slots: wakeup, then issue free, then dispatch write.
  // Flush overrides everything.
  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    occ_d    = occ_q;
    for (int i = 0; i < ENT_NUM; i++) begin
      s1_tag_d[i] = s1_tag_q[i];
      s2_tag_d[i] = s2_tag_q[i];
    end

    if (flush) begin
      valid_d  = {ENT_NUM{1'b0}};
      s1_rdy_d = {ENT_NUM{1'b0}};
      s2_rdy_d = {ENT_NUM{1'b0}};
      occ_d    = {(ENT_SEL+1){1'b0}};
    end else begin
      // Wakeup only affects occupied slots. A FREE slot keeps its stale bits cleared.
      for (int i = 0; i < ENT_NUM; i++) begin
        s1_rdy_d[i] = s1_rdy_q[i] | (valid_q[i] & tag_hit(wk_valid, wk_tag, s1_tag_q[i]));
        s2_rdy_d[i] = s2_rdy_q[i] | (valid_q[i] & tag_hit(wk_valid, wk_tag, s2_tag_q[i]));
      end

      // Issue wins over a same-cycle wakeup of the issued slot.
      if (issue_fire_s) begin
        valid_d[selected_ent]  = 1'b0;
        s1_rdy_d[selected_ent] = 1'b0;
        s2_rdy_d[selected_ent] = 1'b0;
      end else begin
        valid_d[selected_ent]  = valid_d[selected_ent];
      end

      // The dispatch slot is free this cycle, so it never collides with the issued slot.
      if (disp_fire_s) begin
        valid_d[disp_ent]  = 1'b1;
        s1_rdy_d[disp_ent] = disp_s1_rdy_s;
        s2_rdy_d[disp_ent] = disp_s2_rdy_s;
        s1_tag_d[disp_ent] = disp_s1_tag;
        s2_tag_d[disp_ent] = disp_s2_tag;
      end else begin
        valid_d[disp_ent]  = valid_d[disp_ent];
      end

      occ_d = occ_q + {{ENT_SEL{1'b0}}, disp_fire_s} - {{ENT_SEL{1'b0}}, issue_fire_s};
    end
  end

  // Slot state and occupancy registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= {ENT_NUM{1'b0}};
      s1_rdy_q <= {ENT_NUM{1'b0}};
      s2_rdy_q <= {ENT_NUM{1'b0}};
      occ_q    <= {(ENT_SEL+1){1'b0}};
      for (int i = 0; i < ENT_NUM; i++) begin
        s1_tag_q[i] <= {TAG_W{1'b0}};
        s2_tag_q[i] <= {TAG_W{1'b0}};
      end
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      occ_q    <= occ_d;
      for (int i = 0; i < ENT_NUM; i++) begin
        s1_tag_q[i] <= s1_tag_d[i];
        s2_tag_q[i] <= s2_tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_iq_entry_ctrl.sv
// Bench for iq_entry_ctrl: directed scenarios followed by random traffic. The
// outputs are compared against a slot-table reference model kept in this bench.
module tb_iq_entry_ctrl;
  localparam int N = 16;
  localparam int S = 4;
  localparam int T = 6;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         disp_valid = 1'b0, disp_ready;
  logic [S-1:0] disp_ent;
  logic         disp_s1_rdy = 1'b0, disp_s2_rdy = 1'b0;
  logic [T-1:0] disp_s1_tag = '0, disp_s2_tag = '0;
  logic         wk_valid = 1'b0;
  logic [T-1:0] wk_tag = '0;
  logic [N-1:0] request;
  logic         grant = 1'b0;
  logic [S-1:0] selected_ent = '0;
  logic         flush = 1'b0;
  logic [S:0]   occupancy;
  logic         empty;

  always #5 clk = ~clk;

  iq_entry_ctrl #(.ENT_NUM(N), .ENT_SEL(S), .TAG_W(T)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ent(disp_ent),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag),
    .wk_valid(wk_valid), .wk_tag(wk_tag), .request(request),
    .grant(grant), .selected_ent(selected_ent), .flush(flush),
    .occupancy(occupancy), .empty(empty)
  );

  // Reference model: a table of occupied slots with their source state.
  bit           m_v  [N];
  bit           m_r1 [N];
  bit           m_r2 [N];
  logic [T-1:0] m_t1 [N];
  logic [T-1:0] m_t2 [N];
  int checks = 0;
  int failures = 0;

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_v[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [N-1:0] exp_request();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = '0; m_t2[i] = '0;
    end
  endtask

  // Applies one clock edge worth of the slot rules to the model.
  task automatic model_edge();
    int nf;
    bit take, give;
    if (flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      return;
    end
    nf   = lowest_free();
    take = disp_valid && (nf >= 0);
    give = grant && m_v[selected_ent];
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && wk_valid && wk_tag == m_t1[i]) m_r1[i] = 1;
      if (m_v[i] && wk_valid && wk_tag == m_t2[i]) m_r2[i] = 1;
    end
    if (give) m_v[selected_ent] = 0;
    if (take) begin
      m_v[nf]  = 1;
      m_t1[nf] = disp_s1_tag;
      m_t2[nf] = disp_s2_tag;
      m_r1[nf] = disp_s1_rdy || (BYP && wk_valid && wk_tag == disp_s1_tag);
      m_r2[nf] = disp_s2_rdy || (BYP && wk_valid && wk_tag == disp_s2_tag);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int nf = lowest_free();
    int c  = count_valid();
    chk("request", 32'(request), 32'(exp_request()));
    chk("disp_ready", 32'(disp_ready), 32'(nf >= 0));
    if (nf >= 0) chk("disp_ent", 32'(disp_ent), 32'(nf));
    chk("occupancy", 32'(occupancy), 32'(c));
    chk("empty", 32'(empty), 32'(c == 0));
  endtask

  task automatic idle();
    disp_valid = 0; disp_s1_rdy = 0; disp_s2_rdy = 0; disp_s1_tag = '0; disp_s2_tag = '0;
    wk_valid = 0; wk_tag = '0; grant = 0; selected_ent = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset: outputs must clear without any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  task automatic dispatch(input bit r1, input logic [T-1:0] t1, input bit r2, input logic [T-1:0] t2);
    disp_valid = 1; disp_s1_rdy = r1; disp_s1_tag = t1; disp_s2_rdy = r2; disp_s2_tag = t2;
    tick();
    idle();
  endtask

  initial begin
    logic [N-1:0] rq;
    int st;
    idle();
    model_clear();
    @(negedge clk);
    check_all();
    do_reset();

    // Three ready dispatches go to slots 0,1,2.
    for (int k = 0; k < 3; k++) begin
      chk("disp_ent_seq", 32'(disp_ent), 32'(k));
      dispatch(1, 6'd1, 1, 6'd2);
    end
    chk("req_3", 32'(request), 32'h0007);
    chk("occ_3", 32'(occupancy), 32'd3);

    // Waiting source woken by tag 5.
    dispatch(0, 6'd5, 1, 6'd0);
    chk("wait_bit", 32'(request[3]), 32'd0);
    wk_valid = 1; wk_tag = 6'd5;
    tick();
    idle();
    chk("woken_bit", 32'(request[3]), 32'd1);

    // Fill to full, then free slot 7.
    for (int k = 0; k < 20 && lowest_free() >= 0; k++) dispatch(1, 6'd3, 1, 6'd4);
    chk("full_ready", 32'(disp_ready), 32'd0);
    grant = 1; selected_ent = 4'd7;
    tick();
    idle();
    chk("free7_ready", 32'(disp_ready), 32'd1);
    chk("free7_ent", 32'(disp_ent), 32'd7);
    chk("free7_occ", 32'(occupancy), 32'd15);

    // Dispatch and issue in the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) dispatch(1, 6'd1, 1, 6'd1);
    disp_valid = 1; disp_s1_rdy = 1; disp_s2_rdy = 1; grant = 1; selected_ent = 4'd2;
    tick();
    idle();
    chk("swap_occ", 32'(occupancy), 32'd4);
    chk("swap_req", 32'(request), 32'h001B);

    // Wakeup coincident with dispatch.
    do_reset();
    disp_valid = 1; disp_s1_rdy = 0; disp_s1_tag = 6'd9; disp_s2_rdy = 1;
    wk_valid = 1; wk_tag = 6'd9;
    tick();
    idle();
    chk("bypass_bit", 32'(request[0]), 32'(BYP));

    // Flush beats pending dispatch and grant.
    do_reset();
    for (int k = 0; k < 10; k++) dispatch(1, 6'd2, 1, 6'd2);
    disp_valid = 1; disp_s1_rdy = 1; disp_s2_rdy = 1; grant = 1; selected_ent = 4'd0; flush = 1;
    tick();
    idle();
    chk("flush_req", 32'(request), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);

    // Mid-run asynchronous reset.
    for (int k = 0; k < 5; k++) dispatch(1, 6'd2, 1, 6'd2);
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);

    // Grant to a free slot is ignored.
    dispatch(1, 6'd0, 1, 6'd0);
    grant = 1; selected_ent = 4'd9;
    tick();
    idle();
    chk("bad_grant_occ", 32'(occupancy), 32'd1);

    // Random traffic.
    for (int cyc = 0; cyc < 800; cyc++) begin
      disp_valid  = ($urandom_range(0, 3) != 0);
      disp_s1_rdy = ($urandom_range(0, 2) == 0);
      disp_s2_rdy = ($urandom_range(0, 2) == 0);
      disp_s1_tag = T'($urandom_range(0, 7));
      disp_s2_tag = T'($urandom_range(0, 7));
      wk_valid    = ($urandom_range(0, 1) != 0);
      wk_tag      = T'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 63) == 0);
      grant       = ($urandom_range(0, 2) != 0);
      st          = $urandom_range(0, N - 1);
      selected_ent = S'(st);
      rq = exp_request();
      if (rq != '0 && $urandom_range(0, 4) != 0) begin
        for (int k = 0; k < N; k++) begin
          if (rq[(st + k) % N]) begin
            selected_ent = S'((st + k) % N);
            break;
          end
        end
      end
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
